flood_fill_ctrl: RTL

FLOOD_FILL_CTRL -- requirements
Module: flood_fill_ctrl

---
 rtl/flood_fill_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/flood_fill_ctrl.sv
// Flood-fill opener for a minesweeper-style board.
// It starts at an origin cell and walks a LIFO stack of cell coordinates.
// It reads the board and cover arrays through a registered address with one
// cycle of latency. Every still-covered cell it pops is opened. Zero-count
// cells are expanded to their eight neighbours.
module flood_fill_ctrl #(
  parameter int X_SIZE      = 16,
  parameter int Y_SIZE      = 16,
  parameter int X_BITS      = 4,
  parameter int Y_BITS      = 4,
  parameter int STACK_DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [X_BITS-1:0]        start_x,
  input  logic [Y_BITS-1:0]        start_y,
  output logic [X_BITS-1:0]        rd_x,
  output logic [Y_BITS-1:0]        rd_y,
  input  logic [4:0]               rd_board,
  input  logic [1:0]               rd_cover,
  output logic                     open_req,
  output logic [X_BITS-1:0]        open_x,
  output logic [Y_BITS-1:0]        open_y,
  output logic                     busy,
  output logic                     done,
  output logic [X_BITS+Y_BITS:0]   opened_count,
  output logic                     overflow
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = X_BITS + Y_BITS + 1;
  localparam int ENT_W = X_BITS + Y_BITS;

  localparam logic [X_BITS:0] X_LIM   = (X_BITS+1)'(X_SIZE);
  localparam logic [Y_BITS:0] Y_LIM   = (Y_BITS+1)'(Y_SIZE);
  localparam logic [X_BITS:0] X_ONE   = {{X_BITS{1'b0}}, 1'b1};
  localparam logic [Y_BITS:0] Y_ONE   = {{Y_BITS{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_POP, S_WAIT, S_EVAL, S_PUSH, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   sp_q, sp_d;
  logic [2:0]         nbr_q, nbr_d;
  logic [X_BITS-1:0]  rd_x_q, rd_x_d, open_x_q, open_x_d;
  logic [Y_BITS-1:0]  rd_y_q, rd_y_d, open_y_q, open_y_d;
  logic               open_req_q, open_req_d;
  logic               busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ENT_W-1:0]   stack_mem [STACK_DEPTH];
  logic               push_en;
  logic [ENT_W-1:0]   push_data;
  logic [IDX_W-1:0]   push_idx, top_idx;

  logic [X_BITS:0]    xe, nx;
  logic [Y_BITS:0]    ye, ny;
  logic               in_range;

  // Neighbour coordinate for the current push slot. The extra MSB catches -1
  // so that edge cells never wrap around to the opposite side of the board.
  always_comb begin
    xe = {1'b0, rd_x_q};
    ye = {1'b0, rd_y_q};
    unique case (nbr_q)
      3'd0, 3'd3, 3'd5: nx = xe - X_ONE;
      3'd1, 3'd6:       nx = xe;
      default:          nx = xe + X_ONE;
    endcase
    unique case (nbr_q)
      3'd0, 3'd1, 3'd2: ny = ye - Y_ONE;
      3'd3, 3'd4:       ny = ye;
      default:          ny = ye + Y_ONE;
    endcase
    in_range = !nx[X_BITS] && (nx < X_LIM) && !ny[Y_BITS] && (ny < Y_LIM);
  end

  // Next-state, stack pointer and registered-output logic for the flood walk.
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    nbr_d      = nbr_q;
    rd_x_d     = rd_x_q;
    rd_y_d     = rd_y_q;
    open_req_d = 1'b0;
    open_x_d   = open_x_q;
    open_y_d   = open_y_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    push_en    = 1'b0;
    push_data  = {nx[X_BITS-1:0], ny[Y_BITS-1:0]};
    push_idx   = sp_q[IDX_W-1:0];
    top_idx    = sp_q[IDX_W-1:0] - IDX_ONE;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          push_en   = 1'b1;
          push_data = {start_x, start_y};
          sp_d      = sp_q + PTR_ONE;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_POP;
        end
      end
      S_POP: begin
        if (sp_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          sp_d             = sp_q - PTR_ONE;
          {rd_x_d, rd_y_d} = stack_mem[top_idx];
          state_d          = S_WAIT;
        end
      end
      S_WAIT: state_d = S_EVAL;
      S_EVAL: begin
        state_d = S_POP;
        if (rd_cover == 2'b00) begin
          open_req_d = 1'b1;
          open_x_d   = rd_x_q;
          open_y_d   = rd_y_q;
          cnt_d      = cnt_q + CNT_ONE;
          if (rd_board == 5'd0) begin
            nbr_d   = 3'd0;
            state_d = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        if (in_range) begin
          if (sp_q[PTR_W-1]) begin
            ovf_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + PTR_ONE;
          end
        end
        nbr_d = nbr_q + 3'd1;
        if (nbr_q == 3'd7) state_d = S_POP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sp_q       <= '0;
      nbr_q      <= '0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      open_req_q <= 1'b0;
      open_x_q   <= '0;
      open_y_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      nbr_q      <= nbr_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      open_req_q <= open_req_d;
      open_x_q   <= open_x_d;
      open_y_q   <= open_y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Coordinate stack storage. It is emptied by the pointer, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[push_idx] <= push_data;
  end

  assign rd_x         = rd_x_q;
  assign rd_y         = rd_y_q;
  assign open_req     = open_req_q;
  assign open_x       = open_x_q;
  assign open_y       = open_y_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign opened_count = cnt_q;
  assign overflow     = ovf_q;

endmodule
